// File: rtl/tone_buzzer.sv
// Square-wave buzzer driver: plays one note of NOTE_CYCLES followed by a GAP_CYCLES silence.
// Optional macro TONE_LIVE_EN reloads the half-period from `tone` at every buzz toggle.
module tone_buzzer #(
    parameter int TONE_W      = 15,
    parameter int NOTE_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [TONE_W-1:0] tone,
    output logic              buzz,
    output logic              busy,
    output logic              note_done
);

    localparam int NW = $clog2(NOTE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state;
    logic [TONE_W-1:0] latched_tone;
    logic [TONE_W-1:0] hp_cnt;
    logic [NW-1:0]     note_cnt;
    logic [GW-1:0]     gap_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            latched_tone <= '0;
            hp_cnt       <= '0;
            note_cnt     <= '0;
            gap_cnt      <= '0;
            buzz         <= 1'b0;
            busy         <= 1'b0;
            note_done    <= 1'b0;
        end else begin
            note_done <= 1'b0;
            // stop overrides everything, including a coincident start
            if (stop) begin
                state    <= IDLE;
                hp_cnt   <= '0;
                note_cnt <= '0;
                gap_cnt  <= '0;
                buzz     <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            latched_tone <= tone;
                            hp_cnt       <= '0;
                            note_cnt     <= '0;
                            gap_cnt      <= '0;
                            buzz         <= 1'b0;
                            busy         <= 1'b1;
                            state        <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (latched_tone == '0) begin
                            buzz   <= 1'b0;
                            hp_cnt <= '0;
`ifdef TONE_LIVE_EN
                            latched_tone <= tone;
`endif
                        end else if (hp_cnt == latched_tone - TONE_W'(1)) begin
                            buzz   <= ~buzz;
                            hp_cnt <= '0;
`ifdef TONE_LIVE_EN
                            latched_tone <= tone;
`endif
                        end else begin
                            hp_cnt <= hp_cnt + TONE_W'(1);
                        end
                        // last sounding cycle: silence takes priority over any toggle
                        if (note_cnt == NOTE_LAST) begin
                            state    <= GAP;
                            buzz     <= 1'b0;
                            hp_cnt   <= '0;
                            note_cnt <= '0;
                        end else begin
                            note_cnt <= note_cnt + NW'(1);
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            note_done <= 1'b1;
                            gap_cnt   <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_buzzer.sv
// Scoreboard bench for tone_buzzer: per-cycle expected {buzz,busy,note_done} from a note-timeline model.
module tb_tone_buzzer;
    localparam int TW = 15;
    localparam int N  = 40;
    localparam int G  = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [TW-1:0] tone = '0;
    logic          buzz, busy, note_done;

    always #5 clk = ~clk;

    tone_buzzer #(.TONE_W(TW), .NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .tone(tone),
        .buzz(buzz), .busy(busy), .note_done(note_done)
    );

    logic [2:0] expq[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // model: a note is a timeline offset d (1..N sounding, N+1..N+G silent) plus its tone
    bit m_active = 1'b0;
    int m_d = 0;
    int m_t = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] note_out(input int d, input int t);
        logic b;
        if (d <= N) begin
            b = (t == 0) ? 1'b0 : 1'(((d - 1) / t) % 2);
            return {b, 1'b1, 1'b0};
        end
        return 3'b010;
    endfunction

    function automatic int rt();
`ifdef TONE_LIVE_EN
        return m_t;
`else
        return int'($urandom_range(0, 7));
`endif
    endfunction

    // apply inputs for the current cycle, queue the response expected in the next one
    task automatic step(input bit st, input bit sp, input int tn);
        logic [2:0] e;
        start = st;
        stop  = sp;
        tone  = TW'(tn);
        if (sp) begin
            m_active = 1'b0;
            e = 3'b000;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_d = 1;
                m_t = tn;
                e = note_out(1, tn);
            end else begin
                e = 3'b000;
            end
        end else if (m_d == N + G) begin
            m_active = 1'b0;
            e = 3'b001;
        end else begin
            m_d++;
            e = note_out(m_d, m_t);
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        start = 1'b0;
        stop  = 1'b0;
        expq.delete();
        expq.push_back(3'b000);
        m_active = 1'b0;
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({buzz, busy, note_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: got buzz/busy/done=%b required 000", {buzz, busy, note_done});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        expq.push_back(3'b000);
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            if ({buzz, busy, note_done} !== e) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d: got buzz/busy/done=%b required %b",
                         cyc, {buzz, busy, note_done}, e);
            end
        end
    end

    initial begin
        bit st, sp;
        int tn;
        @(posedge clk);
        #1;
        vectors++;
        if ({buzz, busy, note_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state: got buzz/busy/done=%b required 000", {buzz, busy, note_done});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        expq.push_back(3'b000);

        // basic note, tone ignored while busy
        step(1, 0, 3);
        repeat (55) step(0, 0, rt());
        // rest note
        step(1, 0, 0);
        repeat (55) step(0, 0, rt());
        // back-to-back with start held high
        repeat (110) step(1, 0, 2);
        repeat (3) step(0, 0, 0);
        // abort at offset 20, restart at offset 25
        step(1, 0, 5);
        repeat (19) step(0, 0, rt());
        step(0, 1, 5);
        repeat (4) step(0, 0, 6);
        step(1, 0, 3);
        repeat (55) step(0, 0, rt());
        // simultaneous start and stop in idle
        step(1, 1, 7);
        repeat (3) step(0, 0, 7);
        // async reset in the middle of a note
        step(1, 0, 4);
        repeat (9) step(0, 0, rt());
        mid_reset();
        repeat (3) step(0, 0, 0);
        // randomized traffic
        repeat (1500) begin
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 79) == 0);
            tn = m_active ? rt() : int'($urandom_range(0, 6));
            step(st, sp, tn);
        end
        repeat (3) step(0, 0, 0);
        @(negedge clk);
        #1;
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
